// File: rtl/ifq_pkg.sv
// Shared fetch-queue definitions: line geometry, responder FSM encoding and
// address-split helpers used by the instruction cache.
package ifq_pkg;

    localparam int LINE_W         = 128;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        REFILL = 2'd2,
        RESP   = 2'd3
    } icache_state_t;

    // Line index of a byte address: bits [idx_w+3:4].
    function automatic logic [31:0] line_index(input logic [31:0] pc, input int idx_w);
        return (pc >> 4) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag of a byte address: everything above the index.
    function automatic logic [31:0] line_tag(input logic [31:0] pc, input int idx_w);
        return pc >> (idx_w + 4);
    endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Direct-mapped line storage: valid/tag/data per line. Reads are combinational,
// writes land on the rising edge. Valid bits are flops so they can be bulk-cleared.
module icache_line_ram
    import ifq_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int TAG_W     = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inv,
    input  logic [$clog2(NUM_LINES)-1:0] rd_idx,
    output logic                         rd_valid,
    output logic [TAG_W-1:0]             rd_tag,
    output logic [LINE_W-1:0]            rd_data,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_LINES)-1:0] wr_idx,
    input  logic [TAG_W-1:0]             wr_tag,
    input  logic [LINE_W-1:0]            wr_data
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    data_mem [NUM_LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

    // Valid bits: bulk clear first, then a same-cycle install still sets its line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else begin
            if (inv)
                valid <= '0;
            if (wr_en)
                valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays, written when a refill completes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_responder.sv
// Instruction-cache responder: direct-mapped lookup, four-beat refill from
// memory, one-cycle dout_valid per delivered line, abort/invalidate handling.
// Optional feature macro: ICACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module icache_responder
    import ifq_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              cache_rd_en,
    input  logic              cache_abort,
    input  logic              icache_inv,
    output logic [LINE_W-1:0] dout,
    output logic              dout_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_data,
    input  logic              mem_data_valid
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 4;

    icache_state_t               state;
    logic [1:0]                  beat_cnt;
    logic                        abort_pend;
    logic [WORDS_PER_LINE-1:0][WORD_W-1:0] fill_buf;
    logic [IDX_W-1:0]            req_idx;
    logic [TAG_W-1:0]            req_tag;

    logic [IDX_W-1:0]            lu_idx;
    logic [TAG_W-1:0]            lu_tag;
    logic                        rd_valid;
    logic [TAG_W-1:0]            rd_tag;
    logic [LINE_W-1:0]           rd_data;
    logic                        lookup;
    logic                        hit;
    logic                        miss_start;
    logic                        wr_en;
    logic [LINE_W-1:0]           wr_data;

    assign lu_idx     = IDX_W'(line_index(32'(pc_in), IDX_W));
    assign lu_tag     = TAG_W'(line_tag(32'(pc_in), IDX_W));
    assign lookup     = (state == IDLE) && cache_rd_en && !cache_abort;
    assign hit        = lookup && rd_valid && (rd_tag == lu_tag);
    assign miss_start = lookup && !(rd_valid && (rd_tag == lu_tag));
    assign wr_en      = (state == REFILL) && mem_data_valid && (beat_cnt == 2'd3);
    assign wr_data    = {mem_data, fill_buf[2], fill_buf[1], fill_buf[0]};

    icache_line_ram #(
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .inv      (icache_inv),
        .rd_idx   (lu_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_data  (wr_data)
    );

    // Responder FSM: lookup, memory request handshake, beat counting, response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            beat_cnt   <= 2'd0;
            abort_pend <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            dout_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        dout       <= rd_data;
                        dout_valid <= 1'b1;
                    end else if (miss_start) begin
                        state      <= REQ;
                        mem_req    <= 1'b1;
                        mem_addr   <= pc_in & ~ADDR_W'(15);
                        abort_pend <= 1'b0;
                    end
                end
                REQ: begin
                    if (cache_abort)
                        abort_pend <= 1'b1;
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        beat_cnt <= 2'd0;
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (cache_abort)
                        abort_pend <= 1'b1;
                    if (mem_data_valid) begin
                        beat_cnt <= beat_cnt + 2'd1;
                        if (beat_cnt == 2'd3)
                            state <= RESP;
                    end
                end
                RESP: begin
                    // A redirect seen during the refill (or now) drops the response
                    // but the line is already installed.
                    if (!abort_pend && !cache_abort) begin
                        dout       <= fill_buf;
                        dout_valid <= 1'b1;
                    end
                    abort_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Refill datapath: capture request line address and collect beats.
    always_ff @(posedge clk) begin
        if (miss_start) begin
            req_idx <= lu_idx;
            req_tag <= lu_tag;
        end
        if ((state == REFILL) && mem_data_valid)
            fill_buf[beat_cnt] <= mem_data;
    end

`ifdef ICACHE_STATS_EN
    // Saturating lookup statistics; aborted refills still count as misses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit && (hit_cnt != '1))
                hit_cnt <= hit_cnt + 32'd1;
            if (miss_start && (miss_cnt != '1))
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: directed fetches push expected lines,
// a negedge monitor pops and compares on every dout_valid.
module tb_icache_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  pc_in = '0;
    logic         cache_rd_en = 1'b0;
    logic         cache_abort = 1'b0;
    logic         icache_inv = 1'b0;
    logic [127:0] dout;
    logic         dout_valid;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack = 1'b0;
    logic [31:0]  mem_data = '0;
    logic         mem_data_valid = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int m_hits = 0;
    int m_miss = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    icache_responder dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .cache_rd_en    (cache_rd_en),
        .cache_abort    (cache_abort),
        .icache_inv     (icache_inv),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data),
        .mem_data_valid (mem_data_valid)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every delivered line must match the oldest expected line.
    always @(negedge clk) begin
        if (rst && dout_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dout_valid: got dout=%0h, expected no response", dout);
            end else begin
                check("dout", dout, exp_q.pop_front());
            end
        end
    end

    // One fetch; a miss is served by the bench acting as memory.
    task automatic fetch(input string name, input logic [31:0] pc, input logic exp_miss,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input int ack_dly, input int gap, input int abort_at, input int rst_at);
        logic [31:0] w[4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        @(negedge clk);
        pc_in = pc;
        cache_rd_en = 1'b1;
        if (!exp_miss || (abort_at < 0 && rst_at < 0))
            exp_q.push_back({w3, w2, w1, w0});
        @(negedge clk);
        cache_rd_en = 1'b0;
        check({name, "_mem_req"}, 128'(mem_req), 128'(exp_miss));
        if (!exp_miss) begin
            check({name, "_hit_latency"}, 128'(dout_valid), 128'd1);
            m_hits++;
            return;
        end
        m_miss++;
        check({name, "_mem_addr"}, 128'(mem_addr), 128'({pc[31:4], 4'h0}));
        repeat (ack_dly) @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check({name, "_req_drop"}, 128'(mem_req), 128'd0);
        for (int b = 0; b < 4; b++) begin
            if (b == rst_at) begin
                rst = 1'b0;
                #1;
                check({name, "_rst_mem_req"}, 128'(mem_req), 128'd0);
                check({name, "_rst_dout"}, dout, 128'd0);
                check({name, "_rst_dout_valid"}, 128'(dout_valid), 128'd0);
                @(negedge clk);
                rst = 1'b1;
                m_hits = 0;
                m_miss = 0;
                return;
            end
            mem_data = w[b];
            mem_data_valid = 1'b1;
            @(negedge clk);
            mem_data_valid = 1'b0;
            if (b == abort_at) begin
                cache_abort = 1'b1;
                @(negedge clk);
                cache_abort = 1'b0;
            end
            if (b < 3) repeat (gap) @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stats(input string name);
`ifdef ICACHE_STATS_EN
        check({name, "_hit_cnt"}, 128'(hit_cnt), 128'(m_hits));
        check({name, "_miss_cnt"}, 128'(miss_cnt), 128'(m_miss));
`else
        check({name, "_no_stats_idle"}, 128'(mem_req), 128'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_dout", dout, 128'd0);
        check("reset_dout_valid", 128'(dout_valid), 128'd0);
        check("reset_mem_req", 128'(mem_req), 128'd0);
        check("reset_mem_addr", 128'(mem_addr), 128'd0);
        @(negedge clk);
        rst = 1'b1;

        // Cold miss then same-line hit
        fetch("cold_miss", 32'h40, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44, 2, 0, -1, -1);
        fetch("hit_48", 32'h48, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, -1, -1);

        // Invalidate forces the next access to refill
        @(negedge clk); icache_inv = 1'b1;
        @(negedge clk); icache_inv = 1'b0;
        fetch("inv_miss", 32'h40, 1'b1, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 1, 0, -1, -1);
        fetch("hit_4c", 32'h4C, 1'b0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 0, 0, -1, -1);

        // Conflict on index 4 evicts 0x40
        fetch("conflict_140", 32'h140, 1'b1, 32'h101, 32'h102, 32'h103, 32'h104, 0, 1, -1, -1);
        fetch("evicted_40", 32'h40, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44, 3, 0, -1, -1);

        // rd_en together with abort in IDLE is ignored
        @(negedge clk);
        pc_in = 32'h48; cache_rd_en = 1'b1; cache_abort = 1'b1;
        @(negedge clk);
        cache_rd_en = 1'b0; cache_abort = 1'b0;
        check("abort_idle_dout_valid", 128'(dout_valid), 128'd0);
        check("abort_idle_mem_req", 128'(mem_req), 128'd0);

        // Abort during refill: no response, but line installed
        fetch("abort_refill", 32'h200, 1'b1, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 1, 0, 1, -1);
        fetch("hit_after_abort", 32'h204, 1'b0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 0, 0, -1, -1);
        check_stats("stats_mid");

        // Gapped beats, then reset in mid-refill
        fetch("gap_miss", 32'h300, 1'b1, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 2, 3, -1, -1);
        fetch("gap_hit", 32'h304, 1'b0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 0, 0, -1, -1);
        fetch("rst_refill", 32'h380, 1'b1, 32'hD1, 32'hD2, 32'hD3, 32'hD4, 1, 3, -1, 2);
        fetch("after_rst", 32'h380, 1'b1, 32'hE1, 32'hE2, 32'hE3, 32'hE4, 1, 0, -1, -1);
        check_stats("stats_end");

        repeat (3) @(negedge clk);
        check("pending_responses", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
